// File: rtl/q_add8_seq.sv
// q_add8_seq: streams two int8 buffers through a fixed-latency q_add8 datapath and writes results back.
// Optional running signed MIN/MAX of the written results: define Q_ADD8_SEQ_MINMAX_EN.

module q_add8_seq #(
  parameter int ADDR_W    = 12,
  parameter int ADD_DELAY = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              ABORT,
  input  logic [ADDR_W:0]   LEN,
  input  logic [ADDR_W-1:0] A_BASE,
  input  logic [ADDR_W-1:0] B_BASE,
  input  logic [ADDR_W-1:0] C_BASE,
  input  logic [31:0]       GAIN_CFG,
  input  logic [31:0]       QP_CFG,
  output logic              BUSY,
  output logic              DONE,
  output logic              RD_EN,
  output logic [ADDR_W-1:0] RD_ADDR_A,
  output logic [ADDR_W-1:0] RD_ADDR_B,
  input  logic [7:0]        RD_DATA_A,
  input  logic [7:0]        RD_DATA_B,
  output logic              ADD_EN,
  output logic [7:0]        ADD_A,
  output logic [7:0]        ADD_B,
  output logic [31:0]       GAIN,
  output logic [31:0]       Q_PARAM,
  input  logic              ADD_OUT_EN,
  input  logic [7:0]        ADD_C,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [7:0]        WR_DATA,
  output logic [7:0]        MIN,
  output logic [7:0]        MAX
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FLUSH, S_DONE} state_t;

  // FLUSH must outlast every result still in the datapath: 2 feed stages + ADD_DELAY + 1.
  localparam int                  FLUSH_W    = $clog2(ADD_DELAY + 3);
  localparam logic [FLUSH_W-1:0]  FLUSH_LAST = FLUSH_W'(ADD_DELAY + 2);
  localparam logic [ADDR_W:0]     CNT_ONE    = 1;
  localparam logic [ADDR_W-1:0]   ADDR_ONE   = 1;

  state_t              state;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W:0]     rd_cnt;
  logic [ADDR_W:0]     wr_cnt;
  logic [ADDR_W-1:0]   c_base_q;
  logic [FLUSH_W-1:0]  flush_cnt;
  logic                rd_en_d1;
  logic                wb_ok;

  assign wb_ok = ADD_OUT_EN && !ABORT && ((state == S_ISSUE) || (state == S_DRAIN));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      RD_EN     <= 1'b0;
      RD_ADDR_A <= '0;
      RD_ADDR_B <= '0;
      GAIN      <= '0;
      Q_PARAM   <= '0;
      WR_EN     <= 1'b0;
      WR_ADDR   <= '0;
      WR_DATA   <= '0;
      len_q     <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      c_base_q  <= '0;
      flush_cnt <= '0;
    end else begin
      DONE  <= 1'b0;
      WR_EN <= 1'b0;

      if (wb_ok) begin
        WR_EN   <= 1'b1;
        WR_DATA <= ADD_C;
        WR_ADDR <= c_base_q + wr_cnt[ADDR_W-1:0];
        wr_cnt  <= wr_cnt + CNT_ONE;
      end

      case (state)
        S_IDLE: begin
          if (START) begin
            BUSY <= 1'b1;
            if (LEN == '0) begin
              DONE  <= 1'b1;
              state <= S_DONE;
            end else begin
              len_q     <= LEN;
              c_base_q  <= C_BASE;
              RD_ADDR_A <= A_BASE;
              RD_ADDR_B <= B_BASE;
              GAIN      <= GAIN_CFG;
              Q_PARAM   <= QP_CFG;
              rd_cnt    <= '0;
              wr_cnt    <= '0;
              RD_EN     <= 1'b1;
              state     <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          if (ABORT) begin
            RD_EN     <= 1'b0;
            flush_cnt <= '0;
            state     <= S_FLUSH;
          end else begin
            rd_cnt <= rd_cnt + CNT_ONE;
            if (rd_cnt == len_q - CNT_ONE) begin
              RD_EN <= 1'b0;
              state <= S_DRAIN;
            end else begin
              RD_ADDR_A <= RD_ADDR_A + ADDR_ONE;
              RD_ADDR_B <= RD_ADDR_B + ADDR_ONE;
            end
          end
        end

        S_DRAIN: begin
          if (ABORT) begin
            flush_cnt <= '0;
            state     <= S_FLUSH;
          end else if (wr_cnt == len_q) begin
            DONE  <= 1'b1;
            state <= S_DONE;
          end
        end

        S_FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            BUSY  <= 1'b0;
            state <= S_IDLE;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end

        default: begin
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Operand feed: read data lands one cycle after RD_EN and is registered once more.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_en_d1 <= 1'b0;
      ADD_EN   <= 1'b0;
      ADD_A    <= '0;
      ADD_B    <= '0;
    end else begin
      rd_en_d1 <= RD_EN;
      ADD_EN   <= rd_en_d1;
      ADD_A    <= RD_DATA_A;
      ADD_B    <= RD_DATA_B;
    end
  end

`ifdef Q_ADD8_SEQ_MINMAX_EN
  logic run_start;

  assign run_start = (state == S_IDLE) && START;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      MIN <= 8'h7F;
      MAX <= 8'h80;
    end else if (run_start) begin
      MIN <= 8'h7F;
      MAX <= 8'h80;
    end else if (WR_EN) begin
      if ($signed(WR_DATA) < $signed(MIN)) MIN <= WR_DATA;
      if ($signed(WR_DATA) > $signed(MAX)) MAX <= WR_DATA;
    end
  end
`else
  assign MIN = 8'h7F;
  assign MAX = 8'h80;
`endif

endmodule

// File: tb/tb_q_add8_seq.sv
// Self-checking bench for q_add8_seq with behavioural buffer and datapath (C = A + B) models.
// Expected writes, addresses, latency and extrema come from plain arithmetic over the buffer contents.

module tb_q_add8_seq;

  localparam int ADDR_W    = 12;
  localparam int ADD_DELAY = 8;
  localparam int DEPTH     = 1 << ADDR_W;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              START;
  logic              ABORT;
  logic [ADDR_W:0]   LEN;
  logic [ADDR_W-1:0] A_BASE, B_BASE, C_BASE;
  logic [31:0]       GAIN_CFG, QP_CFG;
  logic              BUSY, DONE, RD_EN;
  logic [ADDR_W-1:0] RD_ADDR_A, RD_ADDR_B;
  logic [7:0]        RD_DATA_A = 8'h00;
  logic [7:0]        RD_DATA_B = 8'h00;
  logic              ADD_EN;
  logic [7:0]        ADD_A, ADD_B;
  logic [31:0]       GAIN, Q_PARAM;
  logic              ADD_OUT_EN = 1'b0;
  logic [7:0]        ADD_C = 8'h00;
  logic              WR_EN;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [7:0]        WR_DATA, MIN, MAX;

  q_add8_seq #(.ADDR_W(ADDR_W), .ADD_DELAY(ADD_DELAY)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT), .LEN(LEN),
    .A_BASE(A_BASE), .B_BASE(B_BASE), .C_BASE(C_BASE),
    .GAIN_CFG(GAIN_CFG), .QP_CFG(QP_CFG),
    .BUSY(BUSY), .DONE(DONE), .RD_EN(RD_EN),
    .RD_ADDR_A(RD_ADDR_A), .RD_ADDR_B(RD_ADDR_B),
    .RD_DATA_A(RD_DATA_A), .RD_DATA_B(RD_DATA_B),
    .ADD_EN(ADD_EN), .ADD_A(ADD_A), .ADD_B(ADD_B),
    .GAIN(GAIN), .Q_PARAM(Q_PARAM),
    .ADD_OUT_EN(ADD_OUT_EN), .ADD_C(ADD_C),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .MIN(MIN), .MAX(MAX)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [7:0] mem_a [DEPTH];
  logic [7:0] mem_b [DEPTH];

  // Buffers answer one cycle after the read strobe; driven mid-cycle so the DUT samples them at the next edge.
  logic              prev_en = 1'b0;
  logic [ADDR_W-1:0] prev_a = '0, prev_b = '0;
  always @(negedge CLK) begin
    RD_DATA_A = prev_en ? mem_a[prev_a] : 8'h00;
    RD_DATA_B = prev_en ? mem_b[prev_b] : 8'h00;
    prev_en   = (RD_EN === 1'b1);
    prev_a    = RD_ADDR_A;
    prev_b    = RD_ADDR_B;
  end

  logic [8:0] dp_pipe [ADD_DELAY] = '{default: 9'h000};
  always @(negedge CLK) begin
    ADD_OUT_EN = dp_pipe[ADD_DELAY-1][8];
    ADD_C      = dp_pipe[ADD_DELAY-1][7:0];
    for (int i = ADD_DELAY - 1; i > 0; i--) dp_pipe[i] = dp_pipe[i-1];
    dp_pipe[0] = {(ADD_EN === 1'b1), ADD_A + ADD_B};
  end

  typedef struct {
    int                c;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  wr_t               wr_q[$];
  int                done_q[$];
  logic [ADDR_W-1:0] rda_q[$];
  logic [ADDR_W-1:0] rdb_q[$];
  int                busy_cnt = 0, add_en_cnt = 0, gain_err = 0;
  logic [31:0]       exp_gain = '0, exp_qp = '0;

  always @(negedge CLK) begin
    if (WR_EN === 1'b1) wr_q.push_back('{c: cyc, addr: WR_ADDR, data: WR_DATA});
    if (DONE === 1'b1) done_q.push_back(cyc);
    if (RD_EN === 1'b1) begin
      rda_q.push_back(RD_ADDR_A);
      rdb_q.push_back(RD_ADDR_B);
    end
    if (BUSY === 1'b1) begin
      busy_cnt++;
      if (GAIN !== exp_gain || Q_PARAM !== exp_qp) gain_err++;
    end
    if (ADD_EN === 1'b1) add_en_cnt++;
  end

  int total = 0;
  int bad   = 0;
  int start_cyc = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clearMonitors();
    wr_q.delete();
    done_q.delete();
    rda_q.delete();
    rdb_q.delete();
    busy_cnt   = 0;
    add_en_cnt = 0;
    gain_err   = 0;
  endtask

  task automatic applyStimulus(input int len, input int a, input int b, input int c,
                               input logic [31:0] g, input logic [31:0] qp);
    @(negedge CLK);
    clearMonitors();
    LEN      = (ADDR_W+1)'(len);
    A_BASE   = ADDR_W'(a);
    B_BASE   = ADDR_W'(b);
    C_BASE   = ADDR_W'(c);
    GAIN_CFG = g;
    QP_CFG   = qp;
    if (len != 0) begin
      exp_gain = g;
      exp_qp   = qp;
    end
    start_cyc = cyc;
    START     = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic waitDone(input int budget, input string name);
    int n;
    n = 0;
    while (done_q.size() == 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (done_q.size() == 0) checkOutput({name, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  function automatic logic [7:0] expSum(input int a, input int b, input int i);
    logic [7:0] s;
    s = mem_a[(a + i) % DEPTH] + mem_b[(b + i) % DEPTH];
    return s;
  endfunction

  task automatic runAndCheck(input string name, input int len, input int a, input int b, input int c,
                             input int exp_lat, input int restart_at);
    logic [31:0]       g, qp;
    logic signed [7:0] mn, mx, d;
    g  = $urandom;
    qp = $urandom;
    applyStimulus(len, a, b, c, g, qp);
    if (restart_at > 0) begin
      repeat (restart_at) @(negedge CLK);
      LEN      = (ADDR_W+1)'(len + 3);
      A_BASE   = ADDR_W'(a + 5);
      GAIN_CFG = ~g;
      QP_CFG   = ~qp;
      START    = 1'b1;
      @(negedge CLK);
      START = 1'b0;
    end
    waitDone(len + ADD_DELAY + 40, name);
    repeat (3) @(negedge CLK);
    checkOutput({name, "_done_count"}, done_q.size(), 1);
    if (done_q.size() > 0) checkOutput({name, "_done_latency"}, done_q[0] - start_cyc, exp_lat);
    checkOutput({name, "_reads"}, rda_q.size(), len);
    checkOutput({name, "_writes"}, wr_q.size(), len);
    checkOutput({name, "_cfg_held"}, gain_err, 0);
    checkOutput({name, "_gain"}, GAIN, g);
    checkOutput({name, "_qparam"}, Q_PARAM, qp);
    mn = 8'sh7F;
    mx = -8'sd128;
    for (int i = 0; i < len; i++) begin
      d = expSum(a, b, i);
      if (d < mn) mn = d;
      if (d > mx) mx = d;
      if (i < rda_q.size()) begin
        checkOutput($sformatf("%s_rda%0d", name, i), rda_q[i], (a + i) % DEPTH);
        checkOutput($sformatf("%s_rdb%0d", name, i), rdb_q[i], (b + i) % DEPTH);
      end
      if (i < wr_q.size()) begin
        checkOutput($sformatf("%s_wa%0d", name, i), wr_q[i].addr, (c + i) % DEPTH);
        checkOutput($sformatf("%s_wd%0d", name, i), wr_q[i].data, $unsigned(d));
      end
    end
`ifdef Q_ADD8_SEQ_MINMAX_EN
    checkOutput({name, "_min"}, MIN, $unsigned(mn));
    checkOutput({name, "_max"}, MAX, $unsigned(mx));
`else
    checkOutput({name, "_min"}, MIN, 32'h7F);
    checkOutput({name, "_max"}, MAX, 32'h80);
`endif
  endtask

  typedef struct {
    int len;
    int a;
    int b;
    int c;
    int lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int len, a, b, c;

    RESET    = 1'b1;
    START    = 1'b0;
    ABORT    = 1'b0;
    LEN      = '0;
    A_BASE   = '0;
    B_BASE   = '0;
    C_BASE   = '0;
    GAIN_CFG = '0;
    QP_CFG   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = 8'($urandom);
      mem_b[i] = 8'($urandom);
    end

    vecs[0] = '{4,  'h010, 'h020, 'h030, 16};
    vecs[1] = '{1,  'h100, 'h200, 'h300, 13};
    vecs[2] = '{3,  'hFFE, 'h005, 'hFFF, 15};
    vecs[3] = '{7,  'h7F0, 'h800, 'h000, 19};
    vecs[4] = '{20, 'hFF0, 'hFF8, 'hFFC, 32};

    repeat (3) @(negedge CLK);
    checkOutput("rst_busy",   BUSY,      0);
    checkOutput("rst_done",   DONE,      0);
    checkOutput("rst_rd_en",  RD_EN,     0);
    checkOutput("rst_add_en", ADD_EN,    0);
    checkOutput("rst_wr_en",  WR_EN,     0);
    checkOutput("rst_rdaddr", RD_ADDR_A, 0);
    checkOutput("rst_gain",   GAIN,      0);
    checkOutput("rst_qparam", Q_PARAM,   0);
    checkOutput("rst_min",    MIN,       32'h7F);
    checkOutput("rst_max",    MAX,       32'h80);
    RESET = 1'b0;
    @(negedge CLK);

    for (int v = 0; v < 5; v++)
      runAndCheck($sformatf("vec%0d", v), vecs[v].len, vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].lat, 0);

    // Known extrema: results {5, -3, 100, 0}
    mem_a['h400] = 8'd5;
    mem_a['h401] = 8'hFD;
    mem_a['h402] = 8'd100;
    mem_a['h403] = 8'd0;
    for (int i = 0; i < 4; i++) mem_b['h500 + i] = 8'd0;
    runAndCheck("minmax", 4, 'h400, 'h500, 'h600, 16, 0);
`ifdef Q_ADD8_SEQ_MINMAX_EN
    checkOutput("minmax_min_const", MIN, 32'hFD);
    checkOutput("minmax_max_const", MAX, 32'h64);
`else
    checkOutput("minmax_min_const", MIN, 32'h7F);
    checkOutput("minmax_max_const", MAX, 32'h80);
`endif

    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 40);
      a   = $urandom_range(0, DEPTH - 1);
      b   = $urandom_range(0, DEPTH - 1);
      c   = $urandom_range(0, DEPTH - 1);
      runAndCheck($sformatf("rnd%0d", r), len, a, b, c, len + ADD_DELAY + 4, 0);
    end

    runAndCheck("restart", 6, 'h0A0, 'h0B0, 'h0C0, 18, 3);

    applyStimulus(0, 'h010, 'h020, 'h030, 32'h1234, 32'h5678);
    waitDone(10, "len0");
    repeat (20) @(negedge CLK);
    checkOutput("len0_done_count", done_q.size(), 1);
    if (done_q.size() > 0) checkOutput("len0_latency", done_q[0] - start_cyc, 1);
    checkOutput("len0_busy_cycles", busy_cnt, 1);
    checkOutput("len0_reads", rda_q.size(), 0);
    checkOutput("len0_add_en", add_en_cnt, 0);
    checkOutput("len0_writes", wr_q.size(), 0);

    applyStimulus(6, 'h040, 'h050, 'h060, 32'hA5A5_0001, 32'h0000_0042);
    @(negedge CLK);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    repeat (ADD_DELAY + 10) @(negedge CLK);
    checkOutput("abort_reads", rda_q.size(), 2);
    checkOutput("abort_writes", wr_q.size(), 0);
    checkOutput("abort_no_done", done_q.size(), 0);
    checkOutput("abort_busy_cycles", busy_cnt, ADD_DELAY + 5);
    checkOutput("abort_idle", BUSY, 0);
    runAndCheck("after_abort", 2, 'h070, 'h080, 'h090, 14, 0);

    applyStimulus(10, 'h123, 'h234, 'h345, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    repeat (4) @(negedge CLK);
    RESET = 1'b1;
    #1;
    checkOutput("midrst_busy",   BUSY,      0);
    checkOutput("midrst_rd_en",  RD_EN,     0);
    checkOutput("midrst_rdaddr", RD_ADDR_A, 0);
    checkOutput("midrst_gain",   GAIN,      0);
    checkOutput("midrst_qparam", Q_PARAM,   0);
    checkOutput("midrst_min",    MIN,       32'h7F);
    checkOutput("midrst_max",    MAX,       32'h80);
    @(negedge CLK);
    RESET = 1'b0;
    wr_q.delete();
    done_q.delete();
    repeat (ADD_DELAY + 10) @(negedge CLK);
    checkOutput("midrst_writes", wr_q.size(), 0);
    checkOutput("midrst_no_done", done_q.size(), 0);
    checkOutput("midrst_idle", BUSY, 0);

    runAndCheck("post_reset", 5, 'h011, 'h022, 'h033, 17, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
